// File: rtl/rp_8bit_trace_pkg.sv
// Shared types and helpers for the rp_8bit fetch trace assembler.
package rp_8bit_trace_pkg;

  // Program word address width of the rp_8bit core.
  localparam int PAW = 22;

  // One assembled instruction as delivered to the logger.
  typedef struct packed {
    logic [PAW-1:0] adr;   // word address of the first word
    logic [31:0]    code;  // [15:0] first word, [31:16] second word
    logic           len;   // 0 = one word, 1 = two words
  } trace_t;

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } trace_state_e;

  // lds/sts: 1001_00??_????_0000; jmp/call: 1001_010?_????_11??.
  function automatic logic is_two_word(bit [15:0] w);
    logic lds_sts;
    logic jmp_call;
    lds_sts  = (w[15:10] == 6'b100100) && (w[3:0] == 4'b0000);
    jmp_call = (w[15:9] == 7'b1001010) && (w[3:2] == 2'b11);
    return lds_sts || jmp_call;
  endfunction

endpackage

// File: rtl/rp_8bit_trace_fifo.sv
// Small synchronous FIFO of trace_t entries. A push while full is
// accepted only when a pop happens in the same cycle.
module rp_8bit_trace_fifo
  import rp_8bit_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  trace_t data_i,
  input  logic   pop_i,
  output trace_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  trace_t      mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is forced to zero when empty so stale storage never shows.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rp_8bit_fetch_trace.sv
// Groups snooped fetch words into whole rp_8bit instructions and queues
// them, tagged with their address, for the disassembler/logger stage.
module rp_8bit_fetch_trace
  import rp_8bit_trace_pkg::*;
#(
  parameter int PAW   = rp_8bit_trace_pkg::PAW,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bus_vld,
  input  logic [PAW-1:0] bus_adr,
  input  logic [15:0]    bus_rdt,
  input  logic           flush,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [PAW-1:0] out_adr,
  output logic [31:0]    out_code,
  output logic           out_len,
  output logic           ovf,
  output logic           err_seq
);

  localparam logic [PAW-1:0] ONE = {{(PAW-1){1'b0}}, 1'b1};

  trace_state_e   state_q, state_d;
  trace_state_e   eff_state;
  logic [PAW-1:0] cap_adr_q, cap_adr_d;
  logic [15:0]    cap_word_q, cap_word_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  logic           push;
  trace_t         push_data;
  trace_t         head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  assign pop = !fifo_empty && out_rdy;

  // Pairing FSM: a flush cancels any partial before this cycle's word is
  // looked at, so the word is then treated as a fresh first word.
  always_comb begin
    state_d    = state_q;
    cap_adr_d  = cap_adr_q;
    cap_word_d = cap_word_q;
    err_d      = err_q;
    push       = 1'b0;
    push_data  = '0;
    eff_state  = flush ? ST_FIRST : state_q;
    if (flush) state_d = ST_FIRST;
    if (bus_vld) begin
      if (eff_state == ST_SECOND && bus_adr == cap_adr_q + ONE) begin
        push           = 1'b1;
        push_data.adr  = cap_adr_q;
        push_data.code = {bus_rdt, cap_word_q};
        push_data.len  = 1'b1;
        state_d        = ST_FIRST;
      end else begin
        if (eff_state == ST_SECOND) err_d = 1'b1;
        if (is_two_word(bus_rdt)) begin
          cap_adr_d  = bus_adr;
          cap_word_d = bus_rdt;
          state_d    = ST_SECOND;
        end else begin
          push           = 1'b1;
          push_data.adr  = bus_adr;
          push_data.code = {16'h0000, bus_rdt};
          push_data.len  = 1'b0;
          state_d        = ST_FIRST;
        end
      end
    end
    ovf_d = ovf_q || (push && fifo_full && !pop);
  end

  // FSM, capture and sticky flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FIRST;
      cap_adr_q  <= '0;
      cap_word_q <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_adr_q  <= cap_adr_d;
      cap_word_q <= cap_word_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  rp_8bit_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_vld  = !fifo_empty;
  assign out_adr  = head.adr;
  assign out_code = head.code;
  assign out_len  = head.len;
  assign ovf      = ovf_q;
  assign err_seq  = err_q;

endmodule

// File: doc/rp_8bit_fetch_trace.md
# rp_8bit_fetch_trace

Testbench-side instruction trace assembler for the rp_8bit core. It snoops accepted program-memory fetch beats and groups the 16-bit words into complete instructions. Two-word opcodes (lds, sts, jmp, call) are paired with their operand word. Each complete instruction is buffered, tagged with its word address, and delivered through a valid/ready handshake to the disassembler/logger stage.

## Interface
Parameters:
- PAW, 22: program word address width.
- DEPTH, 4: output FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset; **synchronous, active-low**.
- bus_vld  input  1  fetch word accepted this cycle.
- bus_adr  input  PAW  word address of the fetched word.
- bus_rdt  input  16  fetched instruction word.
- flush  input  1  core discarded the fetch stream (taken branch, skip, interrupt).
- out_vld  output  1  head FIFO entry valid.
- out_rdy  input  1  consumer accepts head entry.
- out_adr  output  PAW  word address of the instruction's first word.
- out_code  output  32  [15:0] first word, [31:16] second word (0 for 1-word instructions).
- out_len  output  1  0 = 16-bit instruction, 1 = 32-bit instruction.
- ovf  output  1  sticky: a complete instruction was dropped because the FIFO was full.
- err_seq  output  1  sticky: a two-word pair was broken by a non-consecutive address.

## Operation
- Two-word detection on a first word:
  - 1001_000?_????_0000 (lds)
  - 1001_001?_????_0000 (sts)
  - 1001_010?_????_110? (jmp)
  - 1001_010?_????_111? (call)
- FSM states: FIRST (reset state) and SECOND.
- FIRST, bus_vld:
  - If two-word: capture adr/word, go to SECOND.
  - Else: push {adr, {16'h0, word}, len=0}; stay in FIRST.
- SECOND, bus_vld with bus_adr == captured_adr+1 (mod 2^PAW): push {captured_adr, {word, captured_word}, len=1}; go to FIRST.
- SECOND, bus_vld with any other address:
  - Set err_seq and discard the partial.
  - Process the new word exactly as in FIRST.
- flush:
  - In SECOND, discard the partial and return to FIRST; err_seq is not set.
  - Flush and bus_vld in the same cycle: flush takes effect first, and the word is handled as a FIRST word.
  - Flush does not affect the FIFO contents.
- FIFO push when full:
  - If out_rdy is low, the entry is dropped and ovf is set.
  - If out_rdy is high in the same cycle, the pop and push both happen and nothing is dropped.
- Pop on out_vld & out_rdy. out_rdy while empty has no effect.
- ovf and err_seq clear only on reset.
- Reset: FSM → FIRST, FIFO empty, partial discarded. Outputs after reset: out_vld=0, out_adr=0, out_code=0, out_len=0, ovf=0, err_seq=0.
- Reset asserted mid-pair or with a full FIFO loses all content.

## Timing
- Latency:
  - 1-word instruction: fetched at edge N, out_vld=1 after edge N+1 when the FIFO was empty.
  - 2-word instruction: out_vld=1 one cycle after the second word.
- out_* are driven from registered FIFO storage; there is no combinational path from bus_* or out_rdy.
- The head stays stable while out_vld & !out_rdy.
- Throughput: one push and one pop per cycle sustained.
- Address wrap: a first word at 2^PAW−1 pairs with a second word at address 0.

## Structure
- Package rp_8bit_trace_pkg holds:
  - typedef trace_t: packed struct {adr, code[31:0], len}; PAW is a package parameter.
  - Function is_two_word(bit [15:0]).
  - FSM state enum.
- Sub-module rp_8bit_trace_fifo:
  - Generic DEPTH-entry synchronous FIFO of trace_t.
  - Pointers are log2(DEPTH)+1 bits.
  - Outputs full/empty, with registered storage.

## Test plan
- 1-word stream: words 0x0000 at 0x10 and 0x2C01 at 0x11, out_rdy=1 → two entries {0x10, 0x00000000, 0} and {0x11, 0x00002C01, 0}, each 1 cycle after its fetch.
- 2-word pair: 0x940C at 0x20 then 0x1234 at 0x21 → single entry {0x20, 0x1234940C, 1}; nothing emitted after the first word.
- Broken pair: 0x9100 at 0x30, then 0x0000 at 0x40 → err_seq=1, single entry {0x40, 0x00000000, 0}.
- Flush mid-pair: 0x940E at 0x50, flush, then 0x0000 at 0x51 → entry {0x51, 0x0, 0}, err_seq stays 0.
- Backpressure: out_rdy=0, six 1-word fetches → four entries held, ovf=1, head stable. Then out_rdy=1 → entries drain in order. Full FIFO with push and pop in the same cycle → no drop.
- Wrap and reset: 0x9200 at 0x3FFFFF then word at 0x000000 → paired entry. rst_n=0 mid-pair → all outputs 0, FSM in FIRST.
